// File: rtl/rvv_xrf_writeback.sv
// Collects up to NUM_IN retire-lane scalar results per cycle in lane order and drains one per cycle to the regfile.
// Latency 1 cycle (no bypass); in_ready depends only on registered occupancy, so a same-cycle pop never opens input room.
module rvv_xrf_writeback #(
    parameter int NUM_IN = 4,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_IN-1:0]             in_valid,
    input  logic [NUM_IN-1:0][ADDR_W-1:0] in_addr,
    input  logic [NUM_IN-1:0][DATA_W-1:0] in_data,
    output logic [NUM_IN-1:0]             in_ready,
    output logic                          out_valid,
    output logic [ADDR_W-1:0]             out_addr,
    output logic [DATA_W-1:0]             out_data,
    input  logic                          out_ready,
    output logic [$clog2(DEPTH+1)-1:0]    fill_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t                       mem [DEPTH];
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             count;
    logic [CNT_W-1:0]             free;
    logic [CNT_W-1:0]             pushes;
    logic [NUM_IN-1:0]            push_en;
    logic [NUM_IN-1:0][PTR_W-1:0] push_slot;
    logic                         pop;

    always_comb begin
        free     = CNT_W'(DEPTH) - count;
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = !rst && (free > CNT_W'(i));
        end
    end

    // x0 results are consumed but take no slot; the rest pack densely from wr_ptr
    always_comb begin
        pushes    = '0;
        push_en   = '0;
        push_slot = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (in_valid[i] && in_ready[i] && (in_addr[i] != '0)) begin
                push_en[i]   = 1'b1;
                push_slot[i] = wr_ptr + PTR_W'(pushes);
                pushes       = pushes + CNT_W'(1);
            end
        end
    end

    assign pop = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count  <= count + pushes - CNT_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(pushes);
            rd_ptr <= rd_ptr + PTR_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (push_en[i]) begin
                mem[push_slot[i]] <= {in_addr[i], in_data[i]};
            end
        end
    end

    assign out_valid  = (count != '0);
    assign out_addr   = out_valid ? mem[rd_ptr].addr : '0;
    assign out_data   = out_valid ? mem[rd_ptr].data : '0;
    assign fill_level = count;

endmodule

// File: tb/tb_rvv_xrf_writeback.sv
// Randomized and directed bench for rvv_xrf_writeback against a queue-based reference model.
module tb_rvv_xrf_writeback;
    localparam int NUM_IN = 4;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CW     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [NUM_IN-1:0]             in_valid = '0;
    logic [NUM_IN-1:0][ADDR_W-1:0] in_addr = '0;
    logic [NUM_IN-1:0][DATA_W-1:0] in_data = '0;
    logic [NUM_IN-1:0]             in_ready;
    logic                          out_valid;
    logic [ADDR_W-1:0]             out_addr;
    logic [DATA_W-1:0]             out_data;
    logic                          out_ready = 1'b0;
    logic [CW-1:0]                 fill_level;

    int total = 0;
    int bad   = 0;

    ent_t              model_q[$];
    logic [ADDR_W-1:0] seen_q[$];

    rvv_xrf_writeback #(
        .NUM_IN(NUM_IN), .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .out_ready(out_ready),
        .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Free space is whatever the queue has not used before this edge.
    function automatic logic [NUM_IN-1:0] model_ready();
        logic [NUM_IN-1:0] r;
        int                fr;
        fr = DEPTH - model_q.size();
        for (int i = 0; i < NUM_IN; i++) r[i] = (fr > i);
        return r;
    endfunction

    task automatic clk_edge();
        logic [NUM_IN-1:0] rdy;
        rdy = model_ready();
        if (out_valid && out_ready) seen_q.push_back(out_addr);
        @(posedge clk);
        if (rst) begin
            model_q.delete();
        end else begin
            if (out_ready && model_q.size() != 0) void'(model_q.pop_front());
            for (int i = 0; i < NUM_IN; i++)
                if (in_valid[i] && rdy[i] && in_addr[i] != '0)
                    model_q.push_back({in_addr[i], in_data[i]});
        end
        #1;
    endtask

    task automatic drive(input logic [NUM_IN-1:0] v, input logic [ADDR_W-1:0] a0,
                         input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                         input logic [ADDR_W-1:0] a3);
        in_valid   = v;
        in_addr[0] = a0;
        in_addr[1] = a1;
        in_addr[2] = a2;
        in_addr[3] = a3;
        for (int i = 0; i < NUM_IN; i++) in_data[i] = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out_addr, out_data, fill_level, in_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b a=%h d=%h fill=%0d rdy=%b exp all zero",
                     out_valid, out_addr, out_data, fill_level, in_ready);
        end
        clk_edge();
        clk_edge();
        rst = 1'b0;
        clk_edge();
        total++;
        if (in_ready !== 4'b1111) begin
            bad++;
            $display("FAIL reset_release_ready got=%b exp=1111", in_ready);
        end
        total++;
        if (fill_level !== CW'(0) || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_empty got fill=%0d v=%b exp 0 0", fill_level, out_valid);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(4'b0001, 5'd5, 5'd0, 5'd0, 5'd0);
        in_data[0] = 32'hDEADBEEF;
        clk_edge();
        in_valid = '0;
        total++;
        if (out_valid !== 1'b1 || out_addr !== 5'd5 || out_data !== 32'hDEADBEEF || fill_level !== CW'(1)) begin
            bad++;
            $display("FAIL single_head got v=%b a=%0d d=%h fill=%0d exp 1 5 deadbeef 1",
                     out_valid, out_addr, out_data, fill_level);
        end
        clk_edge();
        total++;
        if (fill_level !== CW'(0) || out_valid !== 1'b0 || out_addr !== '0 || out_data !== '0) begin
            bad++;
            $display("FAIL single_drain got fill=%0d v=%b a=%0d d=%h exp 0 0 0 0",
                     fill_level, out_valid, out_addr, out_data);
        end
    endtask

    task automatic test_burst();
        out_ready = 1'b0;
        drive(4'b1111, 5'd1, 5'd2, 5'd3, 5'd4);
        clk_edge();
        drive(4'b1111, 5'd5, 5'd6, 5'd7, 5'd8);
        clk_edge();
        in_valid = '0;
        total++;
        if (fill_level !== CW'(8) || in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL burst_full got fill=%0d rdy=%b exp 8 0000", fill_level, in_ready);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_addr !== ADDR_W'(k) || out_data !== model_q[0].data) begin
                bad++;
                $display("FAIL burst_order k=%0d got v=%b a=%0d d=%h exp a=%0d d=%h",
                         k, out_valid, out_addr, out_data, k, model_q[0].data);
            end
            if (k == 2) begin
                total++;
                if (in_ready !== 4'b0001) begin
                    bad++;
                    $display("FAIL burst_ready_after_pop got=%b exp=0001", in_ready);
                end
            end
            clk_edge();
        end
        total++;
        if (fill_level !== CW'(0) || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL burst_drained got fill=%0d v=%b exp 0 0", fill_level, out_valid);
        end
    endtask

    task automatic test_x0();
        out_ready = 1'b0;
        drive(4'b1111, 5'd0, 5'd7, 5'd0, 5'd9);
        total++;
        if (in_ready !== 4'b1111) begin
            bad++;
            $display("FAIL x0_ready got=%b exp=1111", in_ready);
        end
        clk_edge();
        in_valid = '0;
        total++;
        if (fill_level !== CW'(2) || out_addr !== 5'd7) begin
            bad++;
            $display("FAIL x0_first got fill=%0d a=%0d exp 2 7", fill_level, out_addr);
        end
        out_ready = 1'b1;
        clk_edge();
        total++;
        if (out_addr !== 5'd9 || out_data !== in_data[3]) begin
            bad++;
            $display("FAIL x0_second got a=%0d d=%h exp 9 %h", out_addr, out_data, in_data[3]);
        end
        clk_edge();
        total++;
        if (fill_level !== CW'(0)) begin
            bad++;
            $display("FAIL x0_drained got fill=%0d exp 0", fill_level);
        end
    endtask

    task automatic test_partial();
        seen_q.delete();
        out_ready = 1'b0;
        drive(4'b1111, 5'd10, 5'd11, 5'd12, 5'd13);
        clk_edge();
        drive(4'b0011, 5'd14, 5'd15, 5'd0, 5'd0);
        clk_edge();
        total++;
        if (fill_level !== CW'(6)) begin
            bad++;
            $display("FAIL partial_fill6 got=%0d exp=6", fill_level);
        end
        drive(4'b1111, 5'd16, 5'd17, 5'd18, 5'd19);
        total++;
        if (in_ready !== 4'b0011) begin
            bad++;
            $display("FAIL partial_ready got=%b exp=0011", in_ready);
        end
        clk_edge();
        in_valid = 4'b1100;
        total++;
        if (fill_level !== CW'(8) || in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL partial_full got fill=%0d rdy=%b exp 8 0000", fill_level, in_ready);
        end
        clk_edge();
        in_valid  = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) clk_edge();
        drive(4'b0011, 5'd18, 5'd19, 5'd0, 5'd0);
        total++;
        if (in_ready !== 4'b0111 || fill_level !== CW'(5)) begin
            bad++;
            $display("FAIL partial_represent got rdy=%b fill=%0d exp 0111 5", in_ready, fill_level);
        end
        clk_edge();
        in_valid = '0;
        for (int k = 0; k < 10; k++) clk_edge();
        total++;
        if (seen_q.size() != 10) begin
            bad++;
            $display("FAIL partial_count got=%0d exp=10", seen_q.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                total++;
                if (seen_q[k] !== ADDR_W'(10 + k)) begin
                    bad++;
                    $display("FAIL partial_order idx=%0d got=%0d exp=%0d", k, seen_q[k], 10 + k);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [NUM_IN-1:0] exp_rdy;
        int                full_seen;
        full_seen = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            in_valid  = NUM_IN'($urandom_range(0, 15));
            for (int i = 0; i < NUM_IN; i++) begin
                in_addr[i] = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(1, 31));
                in_data[i] = $urandom;
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            exp_rdy = model_ready();
            if (model_q.size() == DEPTH) full_seen++;
            total++;
            if (in_ready !== exp_rdy) begin
                bad++;
                $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
            end
            total++;
            if (fill_level !== CW'(model_q.size())) begin
                bad++;
                $display("FAIL rnd_fill cyc=%0d got=%0d exp=%0d", cyc, fill_level, model_q.size());
            end
            total++;
            if (model_q.size() != 0) begin
                if (out_valid !== 1'b1 || out_addr !== model_q[0].addr || out_data !== model_q[0].data) begin
                    bad++;
                    $display("FAIL rnd_head cyc=%0d got v=%b a=%0d d=%h exp 1 %0d %h",
                             cyc, out_valid, out_addr, out_data, model_q[0].addr, model_q[0].data);
                end
            end else if (out_valid !== 1'b0 || out_addr !== '0 || out_data !== '0) begin
                bad++;
                $display("FAIL rnd_empty cyc=%0d got v=%b a=%0d d=%h exp 0 0 0",
                         cyc, out_valid, out_addr, out_data);
            end
            clk_edge();
        end
        in_valid = '0;
        total++;
        if (full_seen == 0) begin
            bad++;
            $display("FAIL rnd_full_reached got=0 exp>0");
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        in_valid  = '0;
        for (int k = 0; k < 12; k++) clk_edge();
        out_ready = 1'b0;
        drive(4'b1111, 5'd20, 5'd21, 5'd22, 5'd23);
        clk_edge();
        drive(4'b0001, 5'd24, 5'd0, 5'd0, 5'd0);
        clk_edge();
        in_valid = '0;
        total++;
        if (fill_level !== CW'(5)) begin
            bad++;
            $display("FAIL midrst_fill5 got=%0d exp=5", fill_level);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || fill_level !== CW'(0) || in_ready !== '0 || out_addr !== '0 || out_data !== '0) begin
            bad++;
            $display("FAIL midrst_async got v=%b fill=%0d rdy=%b a=%0d d=%h exp all zero",
                     out_valid, fill_level, in_ready, out_addr, out_data);
        end
        @(posedge clk);
        model_q.delete();
        #1;
        rst = 1'b0;
        drive(4'b0001, 5'd3, 5'd0, 5'd0, 5'd0);
        clk_edge();
        in_valid = '0;
        total++;
        if (out_valid !== 1'b1 || out_addr !== 5'd3 || fill_level !== CW'(1)) begin
            bad++;
            $display("FAIL midrst_fresh got v=%b a=%0d fill=%0d exp 1 3 1", out_valid, out_addr, fill_level);
        end
        out_ready = 1'b1;
        clk_edge();
        total++;
        if (out_valid !== 1'b0 || fill_level !== CW'(0)) begin
            bad++;
            $display("FAIL midrst_nostale got v=%b fill=%0d exp 0 0", out_valid, fill_level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_x0();
        test_partial();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
